mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 123 ++++++++++++
 tb/tb_mem_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-port (fetch/memory stage) arbiter in front of a single-port, fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives the data port fixed priority.
module mem_arb #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DValid,
  output logic        StallF,
  output logic        StallM,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LAT);

  state_t     state;
  logic [3:0] cnt;
  logic       cur_we;
  logic       elig_i;
  logic       elig_d;
  logic       pick_d;
  logic       start;

  // Handshake: a requester raises Req with its address/data and holds all of them
  // stable until its Valid pulse; Req seen in the same cycle as its own Valid is ignored.
  assign elig_i = IReq & ~IValid;
  assign elig_d = DReq & ~DValid;

`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign pick_d = elig_d & (~elig_i | ~last_d);
`else
  assign pick_d = elig_d;
`endif

  assign start     = (state == IDLE) & (elig_i | elig_d);
  assign StallF    = IReq & ~IValid;
  assign StallM    = DReq & ~DValid;
  assign dbg_state = state;

  // The memory command is issued in the grant cycle itself; reset masks it immediately.
  always_comb begin
    MemEn    = reset & start;
    MemWe    = 1'b0;
    MemAddr  = 32'd0;
    MemWdata = 32'd0;
    if (reset && start) begin
      if (pick_d) begin
        MemWe    = DWe;
        MemAddr  = DAddr;
        MemWdata = DWdata;
      end else begin
        MemAddr  = IAddr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      cur_we <= 1'b0;
      IValid <= 1'b0;
      DValid <= 1'b0;
      IRdata <= 32'd0;
      DRdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
      last_d <= 1'b0;
`endif
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= pick_d ? BUSY_D : BUSY_I;
            cnt    <= LAT4;
            cur_we <= pick_d & DWe;
`ifdef MEM_ARB_RR_EN
            last_d <= pick_d;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          cnt <= cnt - 4'd1;
          // cnt reaches 1 in the cycle the memory presents read data
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (state == BUSY_I) begin
              IValid <= 1'b1;
              IRdata <= MemRdata;
            end else begin
              DValid <= 1'b1;
              if (!cur_we) DRdata <= MemRdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: four instances (LAT 1, 2, 3, 15) run the same directed scenarios against a
// cycle-time transaction model and a small memory environment.
module tb_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit done_v [4];

  always @(posedge clk) cyc <= cyc + 1;

`ifdef MEM_ARB_RR_EN
  localparam logic [31:0] BOTH_FIRST = 32'h200;
`else
  localparam logic [31:0] BOTH_FIRST = 32'h24;
`endif

  task automatic chk(input int lat, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL LAT=%0d %s: got %h expected %h (cycle %0d)", lat, name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 15;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int L = lat_of(gi);

    logic        rst_n  = 1'b1;
    logic        ireq   = 1'b0;
    logic [31:0] iaddr  = 32'd0;
    logic        dreq   = 1'b0;
    logic        dwe    = 1'b0;
    logic [31:0] daddr  = 32'd0;
    logic [31:0] dwdata = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic        ivalid, dvalid, stallf, stallm, mem_en, mem_we;
    logic [1:0]  dbg;

    mem_arb #(.LAT(L)) dut (
      .clk(clk), .reset(rst_n),
      .IReq(ireq), .IAddr(iaddr), .IRdata(irdata), .IValid(ivalid),
      .DReq(dreq), .DWe(dwe), .DAddr(daddr), .DWdata(dwdata),
      .DRdata(drdata), .DValid(dvalid),
      .StallF(stallf), .StallM(stallm),
      .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWdata(mem_wdata),
      .MemRdata(mem_rdata), .dbg_state(dbg)
    );

    // Memory environment: returns read data exactly L cycles after the command, noise otherwise.
    logic [31:0] env_mem [logic [31:0]];
    int          rd_at = -1;
    logic [31:0] rd_val = 32'd0;
    always @(negedge clk) begin
      if (rst_n && mem_en) begin
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        else begin
          rd_at  = cyc + L;
          rd_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
        end
      end
    end
    always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == rd_at) ? rd_val : {16'hF00D, cyc[15:0]};
    end

    // Transaction model: a grant at cycle t occupies the memory until t+L and completes at t+L+1.
    logic [31:0] ref_mem [logic [31:0]];
    int          nf = 0, ci = -1, cd = -1, gt = -1;
    bit          ci_rd = 1'b0, cd_rd = 1'b0, gd = 1'b0, last_d = 1'b0;
    logic [31:0] ci_dat = 0, cd_dat = 0, e_ir = 0, e_dr = 0;
    int          g_cyc[$];
    logic [31:0] g_addr[$];
    int          iv_q[$];
    int          dv_q[$];

    always @(negedge clk) begin
      bit ev_i, ev_d, el_i, el_d, win_d, gnt;
      logic [31:0] a, rdv;
      int st;
      if (!rst_n) begin
        nf = 0; ci = -1; cd = -1; gt = -1; e_ir = 0; e_dr = 0; last_d = 1'b0;
        chk(L, "rst_memen", mem_en, 0);
        chk(L, "rst_memwe", mem_we, 0);
        chk(L, "rst_ivalid", ivalid, 0);
        chk(L, "rst_dvalid", dvalid, 0);
        chk(L, "rst_irdata", irdata, 0);
        chk(L, "rst_drdata", drdata, 0);
        chk(L, "rst_stallf", stallf, ireq);
        chk(L, "rst_state", dbg, 0);
      end else begin
        ev_i = (ci == cyc);
        ev_d = (cd == cyc);
        if (ev_i && ci_rd) e_ir = ci_dat;
        if (ev_d && cd_rd) e_dr = cd_dat;
        el_i = ireq && !ev_i;
        el_d = dreq && !ev_d;
        gnt  = (cyc >= nf) && (el_i || el_d);
`ifdef MEM_ARB_RR_EN
        win_d = el_d && (!el_i || !last_d);
`else
        win_d = el_d;
`endif
        chk(L, "memen", mem_en, gnt);
        chk(L, "memwe", mem_we, gnt && win_d && dwe);
        if (gnt) begin
          a = win_d ? daddr : iaddr;
          chk(L, "memaddr", mem_addr, a);
          if (win_d && dwe) chk(L, "memwdata", mem_wdata, dwdata);
          rdv = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
          if (win_d) begin
            cd = cyc + L + 1; cd_rd = !dwe; cd_dat = rdv;
            if (dwe) ref_mem[a] = dwdata;
          end else begin
            ci = cyc + L + 1; ci_rd = 1'b1; ci_dat = rdv;
          end
          gt = cyc; gd = win_d; nf = cyc + L + 1; last_d = win_d;
        end
        chk(L, "ivalid", ivalid, ev_i);
        chk(L, "dvalid", dvalid, ev_d);
        chk(L, "irdata", irdata, e_ir);
        chk(L, "drdata", drdata, e_dr);
        chk(L, "stallf", stallf, ireq && !ev_i);
        chk(L, "stallm", stallm, dreq && !ev_d);
        st = (gt >= 0 && cyc > gt && cyc < nf) ? (gd ? 2 : 1) : 0;
        chk(L, "state", dbg, st);
      end
      if (rst_n && mem_en) begin
        g_cyc.push_back(cyc);
        g_addr.push_back(mem_addr);
      end
      if (ivalid) iv_q.push_back(cyc);
      if (dvalid) dv_q.push_back(cyc);
    end

    task automatic d_acc(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit hold);
      int k;
      dreq = 1'b1; dwe = we; daddr = a; dwdata = wd;
      k = 0;
      do begin @(negedge clk); k++; end while (!dvalid && k < 80);
      chk(L, "d_done", dvalid, 1);
      @(posedge clk); #1;
      if (!hold) dreq = 1'b0;
    endtask

    task automatic i_acc(input logic [31:0] a, input bit hold);
      int k;
      ireq = 1'b1; iaddr = a;
      k = 0;
      do begin @(negedge clk); k++; end while (!ivalid && k < 80);
      chk(L, "i_done", ivalid, 1);
      @(posedge clk); #1;
      if (!hold) ireq = 1'b0;
    endtask

    logic [31:0] pd_a  [3] = '{32'h30, 32'h40, 32'h34};
    bit          pd_we [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] pd_wd [3] = '{32'hAAAA_5555, 32'h0, 32'h0BAD_CAFE};
    logic [31:0] pi_a  [3] = '{32'h30, 32'h50, 32'h34};

    initial begin
      int s, r, n0, v0, rc;
      env_mem[32'h40] = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single data read of 0x40
      s = cyc; n0 = g_cyc.size(); v0 = dv_q.size();
      d_acc(1'b0, 32'h40, 32'h0, 1'b0);
      chk(L, "a_grants", g_cyc.size() - n0, 1);
      chk(L, "a_grant_cyc", g_cyc[n0], s);
      chk(L, "a_dvalid_cyc", dv_q[v0], s + L + 1);
      chk(L, "a_drdata", drdata, 32'hDEAD_BEEF);

      // Both ports from reset, held continuously: D, I, D, I
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      s = cyc; n0 = g_cyc.size(); v0 = iv_q.size();
      fork
        begin d_acc(1'b0, 32'h40, 32'h0, 1'b1); d_acc(1'b0, 32'h40, 32'h0, 1'b0); end
        begin i_acc(32'h100, 1'b1); i_acc(32'h104, 1'b0); end
      join
      chk(L, "b_g0_cyc", g_cyc[n0], s);
      chk(L, "b_g0_addr", g_addr[n0], 32'h40);
      chk(L, "b_g1_cyc", g_cyc[n0 + 1], s + L + 1);
      chk(L, "b_g1_addr", g_addr[n0 + 1], 32'h100);
      chk(L, "b_g2_cyc", g_cyc[n0 + 2], s + 2 * L + 2);
      chk(L, "b_g3_addr", g_addr[n0 + 3], 32'h104);
      chk(L, "b_ivalid_cyc", iv_q[v0], s + 2 * L + 2);

      // Data write leaves DRdata alone; read-back returns the stored word
      s = cyc; v0 = dv_q.size();
      d_acc(1'b1, 32'h10, 32'h1234_5678, 1'b0);
      chk(L, "c_drdata_held", drdata, 32'hDEAD_BEEF);
      chk(L, "c_dvalid_cyc", dv_q[v0], s + L + 1);
      d_acc(1'b0, 32'h10, 32'h0, 1'b0);
      chk(L, "c_readback", drdata, 32'h1234_5678);

      // Simultaneous requests after a D-only grant
      d_acc(1'b0, 32'h20, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      s = cyc; n0 = g_cyc.size();
      fork
        d_acc(1'b0, 32'h24, 32'h0, 1'b0);
        i_acc(32'h200, 1'b0);
      join
      chk(L, "d_first_addr", g_addr[n0], BOTH_FIRST);
      chk(L, "d_second_cyc", g_cyc[n0 + 1], s + L + 1);

      // Reset in the middle of an instruction read, IReq held through it
      rc = (L > 1) ? 2 : 1;
      s = cyc; r = 0; v0 = iv_q.size();
      fork
        i_acc(32'h300, 1'b0);
        begin
          repeat (rc) @(posedge clk);
          #1 rst_n = 1'b0;
          @(negedge clk);
          chk(L, "e_irdata_cleared", irdata, 0);
          chk(L, "e_memen_off", mem_en, 0);
          repeat (2) @(posedge clk);
          #1 rst_n = 1'b1;
          r = cyc; n0 = g_cyc.size();
        end
      join
      chk(L, "e_regrant_cyc", g_cyc[n0], r);
      chk(L, "e_ivalid_cyc", iv_q[v0], r + L + 1);

      // Contending pairs mixing writes and reads of shared addresses
      for (int p = 0; p < 3; p++) begin
        fork
          d_acc(pd_we[p], pd_a[p], pd_wd[p], 1'b0);
          i_acc(pi_a[p], 1'b0);
        join
      end
      repeat (3) @(posedge clk);
      done_v[gi] = 1'b1;
    end
  end

  initial begin
    int k;
    k = 0;
    while (!(done_v[0] && done_v[1] && done_v[2] && done_v[3]) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (!(done_v[0] && done_v[1] && done_v[2] && done_v[3])) begin
      errors++;
      $display("FAIL finish_timeout: got not-done expected all scenarios done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
